// File: rtl/ibex_dummy_reseed_ctrl.sv
// Dummy-instruction seed controller: counts inserted dummies, fetches fresh entropy
// over the EDN handshake and loads it into the generator. Optional macro: IBEX_DUMMY_RESEED_TIMEOUT_EN.
`timescale 1ns/1ps
module ibex_dummy_reseed_ctrl #(
    parameter int unsigned PERIOD_W       = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                ctrl_en_i,
    input  logic [PERIOD_W-1:0] reseed_period_i,
    input  logic                sw_reseed_i,
    input  logic                insert_dummy_instr_i,
    input  logic                id_in_ready_i,
    output logic                edn_req_o,
    input  logic                edn_ack_i,
    input  logic [31:0]         edn_data_i,
    output logic                seed_en_o,
    output logic [31:0]         seed_o,
    output logic                busy_o,
    output logic                reseed_err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        LOAD = 2'd2
    } state_e;

    state_e              state_reg, state_next;
    logic [PERIOD_W-1:0] cnt_reg, cnt_next;
    logic                sw_pending_reg, sw_pending_next;
    logic [31:0]         seed_reg, seed_next;
    logic                insert_evt;
    logic                auto_trig;
    logic                trig;
    logic                timeout_hit;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    assign insert_evt = insert_dummy_instr_i & id_in_ready_i;
    assign auto_trig  = ctrl_en_i && (reseed_period_i != '0) && (cnt_reg >= reseed_period_i);
    assign trig       = auto_trig | sw_reseed_i | sw_pending_reg;

`ifdef IBEX_DUMMY_RESEED_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] tmo_cnt_reg, tmo_cnt_next;
    logic       err_reg;

    // Counter restarts from zero on every entry into REQ.
    assign tmo_cnt_next = (state_reg == REQ) ? tmo_cnt_reg + 8'd1 : 8'd0;
    assign timeout_hit  = (state_reg == REQ) && !edn_ack_i && (tmo_cnt_reg == TMO_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt_reg <= 8'd0;
            err_reg     <= 1'b0;
        end else begin
            tmo_cnt_reg <= tmo_cnt_next;
            err_reg     <= timeout_hit;
        end
    end

    assign reseed_err_o = err_reg;
`else
    assign timeout_hit  = 1'b0;
    assign reseed_err_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            sw_pending_reg <= 1'b0;
            seed_reg       <= 32'd0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            sw_pending_reg <= sw_pending_next;
            seed_reg       <= seed_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (trig) state_next = REQ;
            REQ: begin
                if (edn_ack_i)        state_next = LOAD;
                else if (timeout_hit) state_next = IDLE;
            end
            LOAD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Counter saturates at the period so a stalled handshake cannot wrap it.
    always_comb begin
        cnt_next = cnt_reg;
        if (!ctrl_en_i || (reseed_period_i == '0) || (state_reg == LOAD) || timeout_hit) begin
            cnt_next = '0;
        end else if (insert_evt && (cnt_reg < reseed_period_i)) begin
            cnt_next = cnt_reg + PERIOD_W'(1);
        end
    end

    always_comb begin
        sw_pending_next = sw_pending_reg;
        if (state_reg == IDLE) begin
            if (trig) sw_pending_next = 1'b0;
        end else if (sw_reseed_i) begin
            sw_pending_next = 1'b1;
        end
    end

    always_comb begin
        seed_next = seed_reg;
        if ((state_reg == REQ) && edn_ack_i) seed_next = edn_data_i;
    end

    always_comb begin
        edn_req_o = (state_reg == REQ);
        seed_en_o = (state_reg == LOAD);
        busy_o    = (state_reg != IDLE);
        seed_o    = seed_reg;
    end

endmodule

// File: tb/tb_ibex_dummy_reseed_ctrl.sv
// Self-checking bench for ibex_dummy_reseed_ctrl: directed vector table, multi-cycle
// corner sequences and a randomized run against a phase-level reference model.
`timescale 1ns/1ps
module tb_ibex_dummy_reseed_ctrl;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ctrl_en;
    logic [15:0] period;
    logic        sw;
    logic        ins;
    logic        rdy;
    logic        ack;
    logic [31:0] data;
    logic        edn_req;
    logic        seed_en;
    logic [31:0] seed;
    logic        busy;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ibex_dummy_reseed_ctrl #(.PERIOD_W(16), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .ctrl_en_i           (ctrl_en),
        .reseed_period_i     (period),
        .sw_reseed_i         (sw),
        .insert_dummy_instr_i(ins),
        .id_in_ready_i       (rdy),
        .edn_req_o           (edn_req),
        .edn_ack_i           (ack),
        .edn_data_i          (data),
        .seed_en_o           (seed_en),
        .seed_o              (seed),
        .busy_o              (busy),
        .reseed_err_o        (err)
    );

    typedef struct {
        logic        ctrl;
        logic [15:0] per;
        logic        ins;
        logic        sw;
        logic        ack;
        logic [31:0] dat;
        logic        e_req;
        logic        e_en;
        logic [31:0] e_seed;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    // Reference model: phase 0 = waiting, 1 = asking for entropy, 2 = loading
    bit model_on = 0;
    int m_phase, m_cnt, m_wait;
    bit m_pend, m_err;
    logic [31:0] m_seed;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic e_req, input logic e_en,
                              input logic [31:0] e_seed, input logic e_busy, input logic e_err);
        chk({tag, ".edn_req"}, {31'd0, edn_req}, {31'd0, e_req});
        chk({tag, ".seed_en"}, {31'd0, seed_en}, {31'd0, e_en});
        chk({tag, ".seed"}, seed, e_seed);
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, e_busy});
        chk({tag, ".err"}, {31'd0, err}, {31'd0, e_err});
    endtask

    task automatic drive(input logic c, input logic [15:0] p, input logic i, input logic r,
                         input logic s, input logic a, input logic [31:0] d);
        ctrl_en = c; period = p; ins = i; rdy = r; sw = s; ack = a; data = d;
    endtask

    task automatic model_reset();
        m_phase = 0; m_cnt = 0; m_wait = 0; m_pend = 0; m_err = 0; m_seed = 32'd0;
    endtask

    task automatic model_step();
        bit go, tmo_now;
        go = (ctrl_en && period != 0 && m_cnt >= int'(period)) || sw || m_pend;
        tmo_now = 0;
`ifdef IBEX_DUMMY_RESEED_TIMEOUT_EN
        tmo_now = (m_phase == 1) && !ack && (m_wait == TMO - 1);
`endif
        m_err = tmo_now;
        if (!ctrl_en || period == 0 || m_phase == 2 || tmo_now) m_cnt = 0;
        else if (ins && rdy) m_cnt = (m_cnt + 1 > int'(period)) ? m_cnt : m_cnt + 1;
        if (m_phase != 0 && sw) m_pend = 1;
        else if (m_phase == 0 && go) m_pend = 0;
        if (m_phase == 0) begin
            if (go) begin m_phase = 1; m_wait = 0; end
        end else if (m_phase == 1) begin
            if (ack) begin m_phase = 2; m_seed = data; end
            else if (tmo_now) m_phase = 0;
            else m_wait++;
        end else begin
            m_phase = 0;
        end
    endtask

    // One clock: inputs already driven; sample outputs at the following falling edge.
    task automatic cycle();
        @(posedge clk);
        if (model_on) model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(0, 16'd0, 0, 0, 0, 0, 32'd0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    function automatic vec_t mk(logic c, logic [15:0] p, logic i, logic s, logic a, logic [31:0] d,
                                logic er, logic ee, logic [31:0] es, logic eb);
        vec_t v;
        v.ctrl = c; v.per = p; v.ins = i; v.sw = s; v.ack = a; v.dat = d;
        v.e_req = er; v.e_en = ee; v.e_seed = es; v.e_busy = eb;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_a, cnt_b, cnt_c;
        logic [31:0] last_data;

        rst_n = 1'b0;
        drive(0, 16'd0, 0, 0, 0, 0, 32'd0);
        #2;
        check_outs("reset", 0, 0, 32'd0, 0, 0);
        do_reset();
        check_outs("post_reset", 0, 0, 32'd0, 0, 0);

        // Periodic reseed: period 4, ack on the third request cycle
        for (int k = 0; k < 4; k++) vecs.push_back(mk(1, 16'd4, 1, 0, 0, 32'd0, 0, 0, 32'd0, 0));
        for (int k = 0; k < 3; k++) vecs.push_back(mk(1, 16'd4, 0, 0, 0, 32'd0, 1, 0, 32'd0, 1));
        vecs.push_back(mk(1, 16'd4, 0, 0, 1, 32'hDEADBEEF, 0, 1, 32'hDEADBEEF, 1));
        vecs.push_back(mk(1, 16'd4, 0, 0, 0, 32'd0, 0, 0, 32'hDEADBEEF, 0));
        vecs.push_back(mk(1, 16'd4, 0, 0, 0, 32'd0, 0, 0, 32'hDEADBEEF, 0));
        // Software reseed with period 0
        vecs.push_back(mk(1, 16'd0, 0, 1, 0, 32'd0, 1, 0, 32'hDEADBEEF, 1));
        vecs.push_back(mk(1, 16'd0, 0, 0, 1, 32'h12345678, 0, 1, 32'h12345678, 1));
        vecs.push_back(mk(1, 16'd0, 0, 0, 0, 32'd0, 0, 0, 32'h12345678, 0));
        // Dropping ctrl_en during REQ does not abort the handshake
        vecs.push_back(mk(1, 16'd2, 1, 0, 0, 32'd0, 0, 0, 32'h12345678, 0));
        vecs.push_back(mk(1, 16'd2, 1, 0, 0, 32'd0, 0, 0, 32'h12345678, 0));
        vecs.push_back(mk(1, 16'd2, 0, 0, 0, 32'd0, 1, 0, 32'h12345678, 1));
        vecs.push_back(mk(0, 16'd2, 0, 0, 0, 32'd0, 1, 0, 32'h12345678, 1));
        vecs.push_back(mk(0, 16'd2, 0, 0, 1, 32'hCAFEF00D, 0, 1, 32'hCAFEF00D, 1));
        vecs.push_back(mk(0, 16'd2, 0, 0, 0, 32'd0, 0, 0, 32'hCAFEF00D, 0));
        vecs.push_back(mk(0, 16'd2, 1, 0, 0, 32'd0, 0, 0, 32'hCAFEF00D, 0));
        vecs.push_back(mk(0, 16'd2, 1, 0, 0, 32'd0, 0, 0, 32'hCAFEF00D, 0));
        vecs.push_back(mk(0, 16'd2, 1, 0, 0, 32'd0, 0, 0, 32'hCAFEF00D, 0));

        foreach (vecs[k]) begin
            drive(vecs[k].ctrl, vecs[k].per, vecs[k].ins, vecs[k].ins, vecs[k].sw, vecs[k].ack, vecs[k].dat);
            cycle();
            check_outs($sformatf("vec%0d", k), vecs[k].e_req, vecs[k].e_en, vecs[k].e_seed, vecs[k].e_busy, 0);
            $display("[TB] vec %0d req=%0b en=%0b seed=%h busy=%0b", k, edn_req, seed_en, seed, busy);
        end

        // Period 0: a hundred insertions never raise a request
        cnt_a = 0;
        for (int k = 0; k < 100; k++) begin
            drive(1, 16'd0, 1, 1, 0, 0, 32'd0);
            cycle();
            if (edn_req) cnt_a++;
        end
        chk("period0_no_req", cnt_a, 0);
        $display("[TB] period0 sweep req_cycles=%0d", cnt_a);

        // Two software strobes during REQ merge into one extra reseed
        cnt_a = 0; cnt_b = 0;
        drive(1, 16'd0, 0, 0, 1, 0, 32'd0); cycle();
        if (edn_req) cnt_b++;
        for (int k = 0; k < 4; k++) begin
            drive(1, 16'd0, 0, 0, (k % 2 == 0), 0, 32'd0);
            cycle();
        end
        last_data = 32'd0;
        for (int k = 0; k < 25; k++) begin
            last_data = $urandom;
            drive(1, 16'd0, 0, 0, 0, 1, last_data);
            cycle();
            if (seed_en) cnt_a++;
        end
        chk("sw_merge_loads", cnt_a, 2);
        chk("sw_merge_idle", {31'd0, busy}, 32'd0);
        chk("sw_merge_first_req", cnt_b, 1);
        $display("[TB] sw merge loads=%0d", cnt_a);

        // Counter saturates while REQ stalls; LOAD clears it
        for (int k = 0; k < 13; k++) begin
            drive(1, 16'd3, 1, 1, 0, 0, 32'd0);
            cycle();
        end
        chk("sat_req_held", {31'd0, edn_req}, 32'd1);
        chk("sat_cnt", {16'd0, dut.cnt_reg}, 32'd3);
        drive(1, 16'd3, 0, 0, 0, 1, 32'hA5A5A5A5); cycle();
        chk("sat_load", {31'd0, seed_en}, 32'd1);
        drive(1, 16'd3, 0, 0, 0, 0, 32'd0); cycle();
        chk("sat_cnt_clear", {16'd0, dut.cnt_reg}, 32'd0);
        cnt_a = 0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            if (busy) cnt_a++;
        end
        chk("sat_no_retrigger", cnt_a, 0);
        for (int k = 0; k < 3; k++) begin
            drive(1, 16'd3, 1, 1, 0, 0, 32'd0); cycle();
        end
        drive(1, 16'd3, 0, 0, 0, 0, 32'd0); cycle();
        chk("sat_retrigger", {31'd0, edn_req}, 32'd1);
        drive(1, 16'd3, 0, 0, 0, 1, 32'h0BADCAFE); cycle();
        drive(0, 16'd3, 0, 0, 0, 0, 32'd0); cycle();
        $display("[TB] saturation sequence seed=%h", seed);

        // Asynchronous reset in the middle of REQ
        drive(0, 16'd0, 0, 0, 1, 0, 32'd0); cycle();
        drive(0, 16'd0, 0, 0, 0, 0, 32'd0); cycle();
        chk("rst_pre_req", {31'd0, edn_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check_outs("rst_async", 0, 0, 32'd0, 0, 0);
        drive(0, 16'd0, 0, 0, 0, 1, 32'h55555555);
        @(negedge clk);
        rst_n = 1'b1;
        cnt_a = 0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (seed_en || busy) cnt_a++;
        end
        chk("rst_no_load", cnt_a, 0);
        $display("[TB] mid-REQ reset activity=%0d", cnt_a);

        // Unacknowledged request
        drive(0, 16'd0, 0, 0, 1, 0, 32'd0); cycle();
        drive(0, 16'd0, 0, 0, 0, 0, 32'd0);
`ifdef IBEX_DUMMY_RESEED_TIMEOUT_EN
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        for (int k = 0; k < 40; k++) begin
            if (edn_req) cnt_a++;
            if (err) cnt_b++;
            if (seed_en) cnt_c++;
            cycle();
        end
        chk("tmo_req_cycles", cnt_a, TMO);
        chk("tmo_err_pulses", cnt_b, 1);
        chk("tmo_no_load", cnt_c, 0);
        $display("[TB] timeout req_cycles=%0d err=%0d", cnt_a, cnt_b);
`else
        cnt_a = 0;
        for (int k = 0; k < 1000; k++) begin
            if (edn_req && !err) cnt_a++;
            cycle();
        end
        chk("no_tmo_held", cnt_a, 1000);
        $display("[TB] no-timeout hold req_cycles=%0d", cnt_a);
        drive(0, 16'd0, 0, 0, 0, 1, 32'd0); cycle();
        drive(0, 16'd0, 0, 0, 0, 0, 32'd0); cycle();
`endif

        // Randomized run against the reference model
        do_reset();
        model_on = 1;
        period = 16'd3;
        for (int k = 0; k < 3000; k++) begin
            logic [15:0] p;
            p = (k % 50 == 0) ? 16'($urandom_range(0, 5)) : period;
            drive($urandom_range(0, 9) != 0, p, 1'($urandom), 1'($urandom),
                  $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 3, $urandom);
            cycle();
            check_outs("rand", m_phase == 1, m_phase == 2, m_seed, m_phase != 0, m_err);
            if (seed_en) $display("[TB] rand cycle %0d reseed seed=%h", k, seed);
        end
        model_on = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
